// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and GF(2^8) helpers for the sequential AES key schedule.
//   - key_len_e  : key-length selector encoding (128/192/256/illegal)
//   - ks_state_e : key-schedule FSM states
//   - nk_of/nr_of: key words / round count for a key length
//   - xtime, gf_mul, sbox, rot_word, inv_mix_columns
// The S-box is computed (multiplicative inverse as x^254 plus the affine
// map) instead of being held as a 256-entry table.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } ks_state_e;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    logic [3:0] n;
    case (kl)
      KL_192:  n = 4'd6;
      KL_256:  n = 4'd8;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    logic [3:0] n;
    case (kl)
      KL_192:  n = 4'd12;
      KL_256:  n = 4'd14;
      default: n = 4'd10;
    endcase
    return n;
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      acc = acc ^ (b[k] ? aa : 8'h00);
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // Inverse is x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  // First key byte lives in bits [31:24] of a word.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Column c occupies bits [127-32c -: 32], first byte on top.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  col;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      r[127-32*c -: 32] = {
        gf_mul(col[31:24], 8'h0e) ^ gf_mul(col[23:16], 8'h0b) ^ gf_mul(col[15:8], 8'h0d) ^ gf_mul(col[7:0], 8'h09),
        gf_mul(col[31:24], 8'h09) ^ gf_mul(col[23:16], 8'h0e) ^ gf_mul(col[15:8], 8'h0b) ^ gf_mul(col[7:0], 8'h0d),
        gf_mul(col[31:24], 8'h0d) ^ gf_mul(col[23:16], 8'h09) ^ gf_mul(col[15:8], 8'h0e) ^ gf_mul(col[7:0], 8'h0b),
        gf_mul(col[31:24], 8'h0b) ^ gf_mul(col[23:16], 8'h0d) ^ gf_mul(col[15:8], 8'h09) ^ gf_mul(col[7:0], 8'h0e)
      };
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// ---------------------------------------------------------------------------
// aes_subword
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
// Ports:
//   din  in  32  input word
//   dout out 32  S-box applied bytewise
// ---------------------------------------------------------------------------
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Bytewise substitution.
  always_comb begin
    dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
// Sequential AES-128/192/256 key expansion, one schedule word per cycle,
// with a registered round-key read port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, key_len, key   expansion request (key left-aligned, first byte
//                         in the top bits; unused tail ignored)
//   busy, done, key_ready status; done is a one-cycle pulse
//   cfg_err               one-cycle pulse for start with key_len=3
//   nr                    round count of the ready schedule, else 0
//   rk_rd_en, rk_idx      round-key read request
//   rk_valid, rk_data,    response one cycle later; w[4*idx] sits in
//   rk_err                rk_data[127:96]; refused reads return 0/err
// Optional: define AES_KS_EQINV_EN to add input rk_inv, which applies
// InvMixColumns to round keys 1..nr-1 (equivalent inverse cipher keys).
// ---------------------------------------------------------------------------
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NK_MAX = 8,
  parameter int NR_MAX = 14,
  parameter int RK_W   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*NK_MAX-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  key_ready,
  output logic                  cfg_err,
  output logic [3:0]            nr,
`ifdef AES_KS_EQINV_EN
  input  logic                  rk_inv,
`endif
  input  logic                  rk_rd_en,
  input  logic [3:0]            rk_idx,
  output logic                  rk_valid,
  output logic [RK_W-1:0]       rk_data,
  output logic                  rk_err
);

  localparam int DEPTH = 4*NR_MAX + 4;

  ks_state_e   state_r, state_nxt_s;
  key_len_e    kl_s;
  logic [3:0]  nk_r, nr_tgt_r;
  logic [5:0]  i_r, last_r;
  logic [2:0]  mod_r;
  logic [7:0]  rcon_r;
  logic [31:0] wmem_r [0:DEPTH-1];

  logic        accept_s, bad_s, last_word_s;
  logic [31:0] w_prev_s, w_back_s, sub_in_s, sub_out_s, temp_s, w_new_s;
  logic [5:0]  base_s;
  logic [127:0] rk_words_s, rk_sel_s;
  logic        rd_ok_s;

  assign kl_s = key_len_e'(key_len);

  // FSM next state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    bad_s       = 1'b0;
    last_word_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (kl_s == KL_BAD) begin
            bad_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nxt_s = ST_EXPAND;
      ST_EXPAND: begin
        if (i_r == last_r) begin
          last_word_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EXPAND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Expansion datapath: one SubWord instance serves both the i mod Nk == 0
  // (after RotWord) and the AES-256 i mod 8 == 4 cases.
  always_comb begin
    w_prev_s = wmem_r[i_r - 6'd1];
    w_back_s = wmem_r[i_r - {2'b00, nk_r}];
    if (mod_r == 3'd0) begin
      sub_in_s = rot_word(w_prev_s);
    end else begin
      sub_in_s = w_prev_s;
    end
    if (mod_r == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((nk_r == 4'd8) && (mod_r == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = w_prev_s;
    end
    w_new_s = w_back_s ^ temp_s;
  end

  aes_subword u_subword (
    .din  (sub_in_s),
    .dout (sub_out_s)
  );

  // FSM state, expansion counters and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      nk_r      <= 4'd4;
      nr_tgt_r  <= 4'd10;
      i_r       <= 6'd0;
      last_r    <= 6'd43;
      mod_r     <= 3'd0;
      rcon_r    <= 8'h01;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_ready <= 1'b0;
      cfg_err   <= 1'b0;
      nr        <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      done    <= last_word_s;
      cfg_err <= bad_s;
      if (accept_s) begin
        nk_r      <= nk_of(kl_s);
        nr_tgt_r  <= nr_of(kl_s);
        last_r    <= {nr_of(kl_s), 2'b11};
        busy      <= 1'b1;
        key_ready <= 1'b0;
        nr        <= 4'd0;
      end else if (last_word_s) begin
        busy      <= 1'b0;
        key_ready <= 1'b1;
        nr        <= nr_tgt_r;
      end else begin
        busy      <= busy;
        key_ready <= key_ready;
        nr        <= nr;
      end
      case (state_r)
        ST_LOAD: begin
          i_r    <= {2'b00, nk_r};
          mod_r  <= 3'd0;
          rcon_r <= 8'h01;
        end
        ST_EXPAND: begin
          i_r   <= i_r + 6'd1;
          // Wrapping i mod Nk tracker, avoids a divider.
          mod_r <= ({1'b0, mod_r} == (nk_r - 4'd1)) ? 3'd0 : mod_r + 3'd1;
          if (mod_r == 3'd0) begin
            rcon_r <= xtime(rcon_r);
          end else begin
            rcon_r <= rcon_r;
          end
        end
        default: begin
          i_r    <= i_r;
          mod_r  <= mod_r;
          rcon_r <= rcon_r;
        end
      endcase
    end
  end

  // Word store: key words in LOAD (tail overwritten later), one word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (state_r == ST_LOAD) begin
      for (int j = 0; j < NK_MAX; j++) begin
        wmem_r[j] <= key[32*NK_MAX-1-32*j -: 32];
      end
    end else if (state_r == ST_EXPAND) begin
      wmem_r[i_r] <= w_new_s;
    end
  end

  // Read-side selection of the four words of a round key.
  always_comb begin
    base_s     = {rk_idx, 2'b00};
    rk_words_s = {wmem_r[base_s], wmem_r[base_s + 6'd1],
                  wmem_r[base_s + 6'd2], wmem_r[base_s + 6'd3]};
    rd_ok_s    = key_ready && (rk_idx <= nr);
`ifdef AES_KS_EQINV_EN
    if (rk_inv && (rk_idx != 4'd0) && (rk_idx < nr)) begin
      rk_sel_s = inv_mix_columns(rk_words_s);
    end else begin
      rk_sel_s = rk_words_s;
    end
`else
    rk_sel_s = rk_words_s;
`endif
  end

  // Registered read response; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_err   <= 1'b0;
    end else begin
      rk_valid <= rk_rd_en;
      if (rk_rd_en) begin
        if (rd_ok_s) begin
          rk_data <= rk_sel_s;
          rk_err  <= 1'b0;
        end else begin
          rk_data <= '0;
          rk_err  <= 1'b1;
        end
      end else begin
        rk_data <= rk_data;
        rk_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
// Directed FIPS-197 vectors; read responses are checked by a scoreboard
// monitor that pops expectations whenever rk_valid is seen.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_rd_en;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rk_idx;
  logic         busy, done, key_ready, cfg_err, rk_valid, rk_err;
  logic [3:0]   nr;
  logic [127:0] rk_data;
`ifdef AES_KS_EQINV_EN
  logic         rk_inv;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_len   (key_len),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_ready (key_ready),
    .cfg_err   (cfg_err),
    .nr        (nr),
`ifdef AES_KS_EQINV_EN
    .rk_inv    (rk_inv),
`endif
    .rk_rd_en  (rk_rd_en),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_data   (rk_data),
    .rk_err    (rk_err)
  );

  localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K3 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K4 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cyc = 0;

  typedef struct {
    logic [127:0] data;
    logic         err;
    logic [3:0]   idx;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Scoreboard monitor: one expectation per read response.
  always @(negedge clk) begin
    if (rst_n && rk_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: response data %h err %b with no pending read", rk_data, rk_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_data_idx%0d", e.idx), rk_data, e.data);
        chk($sformatf("rd_err_idx%0d", e.idx), 128'(rk_err), 128'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
    start   = 1'b1;
    key_len = kl;
    key     = k;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int exp_lat, input logic [3:0] exp_nr, input string nm);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 128'(cyc - start_cyc), 128'(exp_lat));
    chk({nm, "_nr"}, 128'(nr), 128'(exp_nr));
    chk({nm, "_key_ready"}, 128'(key_ready), 128'd1);
    chk({nm, "_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp_d, input logic exp_e);
    exp_t e;
    e.data = exp_d;
    e.err  = exp_e;
    e.idx  = idx;
    sb.push_back(e);
    rk_rd_en = 1'b1;
    rk_idx   = idx;
    tick();
    rk_rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key = '0;
    rk_rd_en = 1'b0; rk_idx = 4'd0;
`ifdef AES_KS_EQINV_EN
    rk_inv = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_key_ready", 128'(key_ready), 128'd0);
    chk("rst_cfg_err", 128'(cfg_err), 128'd0);
    chk("rst_nr", 128'(nr), 128'd0);
    chk("rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("rst_rk_data", rk_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // Illegal key length.
    start = 1'b1; key_len = 2'd3; tick(); start = 1'b0;
    chk("cfg_err_pulse", 128'(cfg_err), 128'd1);
    chk("cfg_err_busy", 128'(busy), 128'd0);
    tick();
    chk("cfg_err_clear", 128'(cfg_err), 128'd0);
    chk("cfg_err_idle", 128'(busy), 128'd0);
    rd(4'd0, 128'h0, 1'b1);

    // AES-128, read refused while expanding.
    do_start(2'd0, K1);
    chk("aes128_busy", 128'(busy), 128'd1);
    rd(4'd2, 128'h0, 1'b1);
    wait_done(41, 4'd10, "aes128a");
    rd(4'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    chk("done_pulse", 128'(done), 128'd0);
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0);
    rd(4'd11, 128'h0, 1'b1);

    do_start(2'd0, K2);
    chk("restart_key_ready", 128'(key_ready), 128'd0);
    chk("restart_nr", 128'(nr), 128'd0);
    wait_done(41, 4'd10, "aes128b");
    rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    // AES-192 with a second start while busy.
    do_start(2'd1, K3);
    repeat (5) tick();
    start = 1'b1; key_len = 2'd0; tick(); start = 1'b0;
    wait_done(47, 4'd12, "aes192");
    rd(4'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    rd(4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, 1'b0);

    // Reset in the middle of an AES-256 expansion.
    do_start(2'd2, K4);
    while (cyc - start_cyc < 20) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    chk("mid_rst_key_ready", 128'(key_ready), 128'd0);
    chk("mid_rst_nr", 128'(nr), 128'd0);
    chk("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("mid_rst_rk_data", rk_data, 128'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 128'(busy), 128'd0);
    rd(4'd14, 128'h0, 1'b1);

    do_start(2'd2, K4);
    wait_done(53, 4'd14, "aes256");
    rd(4'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    rd(4'd1, 128'h101112131415161718191a1b1c1d1e1f, 1'b0);
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0);
    rd(4'd15, 128'h0, 1'b1);
`ifdef AES_KS_EQINV_EN
    rk_inv = 1'b1;
    rd(4'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0);
    rk_inv = 1'b0;
`endif

    repeat (3) tick();
    chk("sb_drain", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
